stream_demux_1to4: RTL and testbench
====================================

// Module: stream_demux_1to4
//
// PURPOSE
//   Buffered 1-to-4 stream demultiplexer with valid/ready handshake on every channel.
//   - Routes each accepted input word to the output channel named by i_Select.
//   - Each output has its own 2-entry FIFO, so a stalled output never blocks traffic to the
//     other outputs.
//   - Used wherever one producer feeds four consumers, e.g. result distribution to
//     functional units.
//
// PARAMETERS
//   WIDTH      32   data channel width in bits
//
// PORTS
//   i_Clock    in   1        single clock, rising edge
//   i_Reset    in   1        asynchronous, active-high reset
//   i_Valid    in   1        input word valid
//   i_Select   in   2        destination channel of the input word (0..3)
//   i_Input    in   WIDTH    input data
//   o_Ready    out  1        input accepted this cycle when i_Valid && o_Ready
//   o_Valid    out  4        o_Valid[k]: channel k head word valid
//   i_Ready    in   4        i_Ready[k]: consumer k takes the head word
//   o_Output0  out  WIDTH    channel 0 head data
//   o_Output1  out  WIDTH    channel 1 head data
//   o_Output2  out  WIDTH    channel 2 head data
//   o_Output3  out  WIDTH    channel 3 head data
//
// BEHAVIOUR
//   - Reset (async assert, sync release): all FIFO counts = 0, o_Valid = 4'b0000,
//     o_Output0..3 = 0, storage cleared. During reset o_Ready = 1; no push is taken.
//   - Push: i_Valid && o_Ready -> word written to FIFO[i_Select].
//   - o_Ready = !full[i_Select]. It is combinational on i_Select only and never depends on
//     i_Ready. i_Select is don't-care when i_Valid = 0.
//   - Pop on channel k: o_Valid[k] && i_Ready[k]. The head advances, and the next entry (if
//     any) is visible the next cycle.
//   - Latency: a word accepted in cycle N is at the channel head (o_Valid[k] = 1) in N+1 at
//     the earliest.
//   - Throughput: 1 word/cycle into any channel whose consumer holds i_Ready = 1.
//   - Per channel: count 0..2, 1-bit write and read pointers that wrap 1 -> 0.
//     o_Valid[k] = (count != 0). o_OutputK = storage[rd_ptr]; its value is held, not
//     zeroed, when count = 0.
//   - Simultaneous push and pop on the same channel:
//     - count 1 or 2: count unchanged, both pointers advance.
//     - count 0: push only. No bypass; the pop cannot occur because o_Valid = 0.
//   - Full channel (count 2) and i_Select targeting it:
//     - o_Ready = 0 even if i_Ready[k] = 1 in the same cycle. This avoids the comb
//       ready->ready path, at the cost of one bubble.
//     - Words for other channels are still accepted on later cycles.
//   - Pushes and pops on different channels in the same cycle are fully independent.
//   - Per-channel order is strictly FIFO. No ordering is guaranteed across channels.
//   - Data stability: while o_Valid[k] = 1 and i_Ready[k] = 0, o_OutputK and o_Valid[k]
//     hold stable.
//   - Reset mid-operation: all buffered words are discarded, with no partial output.
//     o_Valid drops asynchronously with i_Reset.
//
// STRUCTURE
//   - Shared package: localparam NUM_CHANNELS = 4, FIFO_DEPTH = 2; typedef logic [1:0] sel_t.
//   - Sub-module fifo_2entry #(WIDTH): ports i_Clock, i_Reset, i_Push, i_Data, i_Pop,
//     o_Data, o_Valid, o_Full. It is instantiated 4x in a generate loop.
//   - Top level holds only the push decode (one-hot of i_Select gated by i_Valid && o_Ready)
//     and the o_Ready mux.
//
// TESTING
//   1. Reset: assert i_Reset mid-stream with 2 words in channel 1 -> o_Valid = 0000,
//      o_Output0..3 = 0, o_Ready = 1 after release.
//   2. Routing: i_Ready = 1111; push 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 on consecutive
//      cycles -> each appears on o_OutputK exactly one cycle later, o_Valid one-hot,
//      o_Ready always 1.
//   3. Fill/stall: i_Ready[2] = 0; push 0x11,0x22,0x33 to sel 2 ->
//      - first two accepted, o_Ready = 0 on the third;
//      - raise i_Ready[2] -> 0x11 then 0x22 popped, 0x33 accepted once count < 2.
//   4. Independence: channel 3 full and stalled; alternate pushes to sel 3 and sel 0 ->
//      - sel 3 words refused;
//      - sel 0 words 0x5 and 0x6 delivered in order with 1-cycle latency.
//   5. Simultaneous: channel 1 holds 1 word, i_Ready[1] = 1, push 0x77 to sel 1 ->
//      count stays 1, head becomes 0x77 next cycle.
//   6. Random: constrained-random sel, valid and ready for 10k cycles against a
//      4-queue scoreboard -> no loss, duplication or reordering per channel.

Source files
------------

// File: rtl/stream_demux_1to4_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_1to4_pkg
//
// Purpose:
//   Shared definitions for the buffered 1-to-4 stream demultiplexer.
//   Holds the channel count, the per-channel FIFO depth, the select type
//   and a small helper that turns a channel select into a one-hot vector.
//
// Contents:
//   NUM_CHANNELS  number of output channels (4)
//   FIFO_DEPTH    entries per channel FIFO (2)
//   sel_t         channel select type (2 bits)
//   count_t       per-channel occupancy type (0..FIFO_DEPTH)
//   selToOneHot   select -> one-hot channel vector
// ---------------------------------------------------------------------------
package stream_demux_1to4_pkg;

    localparam int NUM_CHANNELS = 4;
    localparam int FIFO_DEPTH   = 2;

    typedef logic [1:0] sel_t;
    typedef logic [1:0] count_t;

    // Decode a channel number into a one-hot vector so the top level can
    // gate it with the accepted-handshake condition in a single AND.
    function automatic logic [NUM_CHANNELS-1:0] selToOneHot(input sel_t sel);
        logic [NUM_CHANNELS-1:0] oneHot;
        oneHot      = '0;
        oneHot[sel] = 1'b1;
        return oneHot;
    endfunction

endpackage

// File: rtl/stream_demux_1to4_fifo.sv
// ---------------------------------------------------------------------------
// fifo_2entry
//
// Purpose:
//   Two-entry first-word-fall-through FIFO used as the per-channel buffer of
//   the 1-to-4 demultiplexer. The head word is presented on o_Data whenever
//   the FIFO holds at least one entry. There is no bypass: a word pushed in
//   one cycle becomes visible at the head in the following cycle.
//
// Ports:
//   i_Clock   in   1       rising-edge clock
//   i_Reset   in   1       asynchronous active-high reset
//   i_Push    in   1       write i_Data (ignored while full)
//   i_Data    in   WIDTH   write data
//   i_Pop     in   1       consumer takes the head word (ignored while empty)
//   o_Data    out  WIDTH   head word; keeps the addressed slot when empty
//   o_Valid   out  1       FIFO holds at least one word
//   o_Full    out  1       FIFO holds FIFO_DEPTH words
// ---------------------------------------------------------------------------
module fifo_2entry
    import stream_demux_1to4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Valid,
    output logic             o_Full
);

    logic [WIDTH-1:0] storage [FIFO_DEPTH];
    count_t           count;
    logic             wrPtr;
    logic             rdPtr;
    logic             doPush;
    logic             doPop;

    // The FIFO protects itself: a push into a full FIFO or a pop from an
    // empty one is dropped, so callers cannot corrupt the occupancy count.
    assign doPush = i_Push && !o_Full;
    assign doPop  = i_Pop  && o_Valid;

    // Storage and pointer update. Reset clears the storage as well as the
    // pointers so that the head data reads as zero straight after reset.
    // Pointers are single bits and simply toggle, which wraps 1 -> 0.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (doPush) begin
                storage[wrPtr] <= i_Data;
                wrPtr          <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
        end
    end

    // Occupancy count. A simultaneous push and pop leaves the count alone;
    // a pop into an empty FIFO never happens because doPop needs o_Valid.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count <= '0;
        end else begin
            case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Status flags come straight from the registered count, so o_Valid
    // falls together with the asynchronous reset.
    assign o_Data  = storage[rdPtr];
    assign o_Valid = (count != 2'd0);
    assign o_Full  = (count == 2'(FIFO_DEPTH));

endmodule

// File: rtl/stream_demux_1to4.sv
// ---------------------------------------------------------------------------
// stream_demux_1to4
//
// Purpose:
//   Buffered 1-to-4 stream demultiplexer. Each accepted input word is routed
//   to the channel named by i_Select and queued in that channel's own
//   two-entry FIFO, so a stalled consumer only blocks traffic addressed to
//   itself. Typical use: one producer distributing results to four
//   functional units.
//
// Ports:
//   i_Clock    in   1       rising-edge clock
//   i_Reset    in   1       asynchronous active-high reset
//   i_Valid    in   1       input word valid
//   i_Select   in   2       destination channel (0..3)
//   i_Input    in   WIDTH   input data
//   o_Ready    out  1       input accepted when i_Valid && o_Ready
//   o_Valid    out  4       per-channel head word valid
//   i_Ready    in   4       per-channel consumer takes the head word
//   o_Output0  out  WIDTH   channel 0 head data
//   o_Output1  out  WIDTH   channel 1 head data
//   o_Output2  out  WIDTH   channel 2 head data
//   o_Output3  out  WIDTH   channel 3 head data
// ---------------------------------------------------------------------------
module stream_demux_1to4
    import stream_demux_1to4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Valid,
    input  logic [1:0]       i_Select,
    input  logic [WIDTH-1:0] i_Input,
    output logic             o_Ready,
    output logic [3:0]       o_Valid,
    input  logic [3:0]       i_Ready,
    output logic [WIDTH-1:0] o_Output0,
    output logic [WIDTH-1:0] o_Output1,
    output logic [WIDTH-1:0] o_Output2,
    output logic [WIDTH-1:0] o_Output3
);

    sel_t                    selIdx;
    logic [NUM_CHANNELS-1:0] fullVec;
    logic [NUM_CHANNELS-1:0] validVec;
    logic [NUM_CHANNELS-1:0] pushVec;
    logic [NUM_CHANNELS-1:0] popVec;
    logic [WIDTH-1:0]        headData [NUM_CHANNELS];

    assign selIdx = i_Select;

    // Ready looks only at the fullness of the addressed channel. It is kept
    // independent of i_Ready on purpose: a full channel refuses a word even
    // when its consumer is draining in the same cycle, which costs one
    // bubble but keeps any combinational ready-to-ready path out of the
    // design. While reset is held every FIFO is empty, so ready reads high.
    assign o_Ready = !fullVec[selIdx];

    // Only the addressed channel sees a push, and only on an accepted
    // handshake.
    assign pushVec = selToOneHot(selIdx) & {NUM_CHANNELS{i_Valid && o_Ready}};

    // A pop is requested whenever the consumer is ready; the FIFO itself
    // ignores the request while it is empty.
    assign popVec = i_Ready;

    // One independent FIFO per output channel.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
        fifo_2entry #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .i_Clock (i_Clock),
            .i_Reset (i_Reset),
            .i_Push  (pushVec[ch]),
            .i_Data  (i_Input),
            .i_Pop   (popVec[ch]),
            .o_Data  (headData[ch]),
            .o_Valid (validVec[ch]),
            .o_Full  (fullVec[ch])
        );
    end

    assign o_Valid   = validVec;
    assign o_Output0 = headData[0];
    assign o_Output1 = headData[1];
    assign o_Output2 = headData[2];
    assign o_Output3 = headData[3];

endmodule

// File: tb/tb_stream_demux_1to4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1to4
//
// Self-checking bench for stream_demux_1to4. A reference model keeps one
// queue of words per channel. The driver decides acceptance from the queue
// occupancy and pushes accepted words; an independent monitor compares the
// DUT heads against the queue fronts every cycle and pops on handshakes.
// ---------------------------------------------------------------------------
module tb_stream_demux_1to4;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             inValid = 1'b0;
    logic [1:0]       inSel = 2'd0;
    logic [WIDTH-1:0] inData = '0;
    logic             outReady;
    logic [3:0]       outValid;
    logic [3:0]       consReady = 4'b0000;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sbQ [4][$];

    stream_demux_1to4 #(
        .WIDTH (WIDTH)
    ) dut (
        .i_Clock   (clock),
        .i_Reset   (reset),
        .i_Valid   (inValid),
        .i_Select  (inSel),
        .i_Input   (inData),
        .o_Ready   (outReady),
        .o_Valid   (outValid),
        .i_Ready   (consReady),
        .o_Output0 (out0),
        .o_Output1 (out1),
        .o_Output2 (out2),
        .o_Output3 (out3)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] dutOut(input int k);
        case (k)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus: drive after the falling edge, check ready once
    // the combinational path has settled, and record an accepted word after
    // the monitor has processed this cycle's pops.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [WIDTH-1:0] d, input logic [3:0] r,
                                 output logic accepted);
        logic expReady;
        @(negedge clock);
        inValid   = v;
        inSel     = s;
        inData    = d;
        consReady = r;
        #1;
        expReady = (sbQ[s].size() < 2);
        checkOutput("o_Ready", 32'(outReady), 32'(expReady));
        accepted = v && expReady;
        #2;
        if (accepted) sbQ[s].push_back(d);
    endtask

    // Asynchronous reset asserted between clock edges, released on a falling
    // edge. Everything buffered is discarded.
    task automatic doReset();
        @(negedge clock);
        #1;
        reset   = 1'b1;
        inValid = 1'b0;
        inSel   = 2'($urandom_range(0, 3));
        #1;
        checkOutput("reset o_Valid", 32'(outValid), 32'd0);
        checkOutput("reset o_Ready", 32'(outReady), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset o_Output%0d", k), dutOut(k), '0);
            sbQ[k].delete();
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("post-reset o_Ready", 32'(outReady), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("post-reset o_Output%0d", k), dutOut(k), '0);
        end
    endtask

    // Monitor: every cycle compare each channel's valid flag and head word
    // against the model, then retire the head on a handshake.
    initial begin
        logic expValid;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                for (int k = 0; k < 4; k++) begin
                    expValid = (sbQ[k].size() != 0);
                    checkOutput($sformatf("o_Valid[%0d]", k), 32'(outValid[k]), 32'(expValid));
                    if (expValid && outValid[k]) begin
                        checkOutput($sformatf("o_Output%0d", k), dutOut(k), sbQ[k][0]);
                    end
                    if (expValid && consReady[k]) begin
                        void'(sbQ[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic acc;

        // Reset with two words sitting in channel 1.
        doReset();
        applyStimulus(1'b1, 2'd1, 32'hC0DE_0001, 4'b0000, acc);
        applyStimulus(1'b1, 2'd1, 32'hC0DE_0002, 4'b0000, acc);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000, acc);
        doReset();

        // Routing to every channel on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 32'hA0 + 32'(i), 4'b1111, acc);
        end
        repeat (2) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Fill and stall channel 2, then release it and retry the third word.
        applyStimulus(1'b1, 2'd2, 32'h11, 4'b1011, acc);
        applyStimulus(1'b1, 2'd2, 32'h22, 4'b1011, acc);
        applyStimulus(1'b1, 2'd2, 32'h33, 4'b1011, acc);
        applyStimulus(1'b0, 2'd2, 32'h0, 4'b1011, acc);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 2'd2, 32'h33, 4'b1111, acc);
            if (acc) break;
        end
        repeat (3) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Channel 3 full and stalled while channel 0 keeps flowing.
        applyStimulus(1'b1, 2'd3, 32'h3A, 4'b0111, acc);
        applyStimulus(1'b1, 2'd3, 32'h3B, 4'b0111, acc);
        applyStimulus(1'b1, 2'd3, 32'h3C, 4'b0111, acc);
        applyStimulus(1'b1, 2'd0, 32'h5,  4'b0111, acc);
        applyStimulus(1'b1, 2'd3, 32'h3D, 4'b0111, acc);
        applyStimulus(1'b1, 2'd0, 32'h6,  4'b0111, acc);
        repeat (4) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Simultaneous push and pop on a channel holding one word.
        applyStimulus(1'b1, 2'd1, 32'h66, 4'b0000, acc);
        applyStimulus(1'b1, 2'd1, 32'h77, 4'b0010, acc);
        applyStimulus(1'b0, 2'd0, 32'h0,  4'b0000, acc);
        repeat (2) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        // Random traffic with one reset in the middle.
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) doReset();
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                          $urandom, 4'($urandom_range(0, 15)), acc);
        end
        repeat (6) applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
